// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU class and PC source selects, and the packed control vector.
package mcu_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDI_WB = 4'd10,
        S_JUMP    = 4'd11,
        S_IDLE    = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Datapath control vector produced by the output decoder
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retired;
    } ctrl_t;

endpackage

// File: rtl/mcu_output_decode.sv
// Moore output decode: state (plus mem_ready for the handshake strobes)
// to datapath control vector. Purely combinational.
// Optional feature macro: MCU_JUMP_EN (enables the JUMP state outputs).
module mcu_output_decode
    import mcu_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl_c
);

    // Per-state strobes; everything not named for a state stays 0
    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                ctrl_c.alu_op    = ALU_ADD;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = 2'b11;
                ctrl_c.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.retired    = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
                ctrl_c.retired   = mem_ready;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.retired   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_op        = ALU_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCS_ALUOUT;
                ctrl_c.retired       = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.retired   = 1'b1;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCS_JUMP;
                ctrl_c.retired   = 1'b1;
            end
`endif
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction sequencer: FSM, retired-instruction counter and
// illegal-opcode detection; outputs decoded by mcu_output_decode.
// Optional feature macro: MCU_JUMP_EN (opcode 000010 executes as a jump;
// when undefined that opcode is illegal and the JUMP state does not exist).
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal,
    output logic                retired,
    output logic [CNT_W-1:0]    instr_count,
    output logic [3:0]          state
);

    state_t           state_q, state_d;
    logic             is_store_q, is_store_d;
    logic             illegal_c;
    logic [CNT_W-1:0] count_q;
    ctrl_t            ctrl_c;

    // Branch resolution happens in the datapath; the FSM never looks at zero
    logic unused_zero;
    assign unused_zero = zero;

    // State, latched lw/sw selector and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            if (ctrl_c.retired) count_q <= count_q + CNT_W'(1);
        end
    end

    // Next state; lw/sw choice is captured in DECODE so opcode is ignored later
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        illegal_c  = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPCODE_W'(OP_RTYPE): state_d = S_EXEC;
                    OPCODE_W'(OP_LW): begin
                        state_d    = S_MEMADR;
                        is_store_d = 1'b0;
                    end
                    OPCODE_W'(OP_SW): begin
                        state_d    = S_MEMADR;
                        is_store_d = 1'b1;
                    end
                    OPCODE_W'(OP_BEQ):   state_d = S_BRANCH;
                    OPCODE_W'(OP_ADDI):  state_d = S_ADDI_EX;
`ifdef MCU_JUMP_EN
                    OPCODE_W'(OP_J):     state_d = S_JUMP;
`endif
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR:  state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
`ifdef MCU_JUMP_EN
            S_JUMP:    state_d = S_FETCH;
`endif
            default:   state_d = S_IDLE;
        endcase
    end

    mcu_output_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl_c    (ctrl_c)
    );

    // Unpack control vector onto the datapath ports
    assign pc_write      = ctrl_c.pc_write;
    assign pc_write_cond = ctrl_c.pc_write_cond;
    assign i_or_d        = ctrl_c.i_or_d;
    assign mem_read      = ctrl_c.mem_read;
    assign mem_write     = ctrl_c.mem_write;
    assign ir_write      = ctrl_c.ir_write;
    assign mem_to_reg    = ctrl_c.mem_to_reg;
    assign reg_dst       = ctrl_c.reg_dst;
    assign reg_write     = ctrl_c.reg_write;
    assign alu_src_a     = ctrl_c.alu_src_a;
    assign alu_src_b     = ctrl_c.alu_src_b;
    assign alu_op        = ctrl_c.alu_op;
    assign pc_source     = ctrl_c.pc_source;
    assign retired       = ctrl_c.retired;
    assign illegal       = illegal_c;
    assign instr_count   = count_q;
    assign state         = state_q;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle successor to the single-cycle opcode decoder in the CPU datapath. A Moore FSM sequences each instruction through fetch, decode, execute, memory and writeback. It drives per-state datapath control strobes and stalls on a memory ready handshake. It also counts retired instructions and flags illegal opcodes. It sits between the instruction register's opcode field and the multicycle datapath (PC, IR, MDR, A/B, ALUOut registers).

## Interface
- OPCODE_W, 6, opcode field width
- CNT_W, 16, retired-instruction counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  OPCODE_W  IR[31:26], stable from DECODE onward
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath strobes/selects
- alu_src_b, alu_op, pc_source  output  2 each  mux selects / ALU class (00 add, 01 sub, 10 funct)
- illegal  output  1  one-cycle pulse on unknown opcode
- retired  output  1  one-cycle pulse on the final cycle of each instruction
- instr_count  output  CNT_W  retired-instruction count
- state  output  4  current state, debug only

## Operation
- States: IDLE=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDI_EX=9, ADDI_WB=10, JUMP=11.
- IDLE → FETCH unconditionally. All outputs are 0 in IDLE.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op=00 held every cycle.
  - ir_write=1 and pc_write=1 only in the cycle mem_ready=1; advance to DECODE on that cycle.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode:
  - 000000 → EXEC
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDI_EX
  - 000010 → JUMP (macro-dependent, see Configuration)
  - anything else → illegal=1, retired=0, next FETCH (treated as NOP, not counted)
- MEMADR: alu_src_a=1, alu_src_b=10. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, i_or_d=1. Wait on mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, retired=1. Next FETCH.
- MEMWR: mem_write=1, i_or_d=1. Wait on mem_ready; retired=1 on the ready cycle, then FETCH.
- EXEC: alu_src_a=1, alu_op=10. Next RWB.
- RWB: reg_write=1, reg_dst=1, retired=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, retired=1. Next FETCH. The datapath gates the PC write with zero; the FSM does not branch on zero.
- ADDI_EX: alu_src_a=1, alu_src_b=10. Next ADDI_WB.
- ADDI_WB: reg_write=1, retired=1. Next FETCH.
- JUMP: pc_write=1, pc_source=10, retired=1. Next FETCH.
- instr_count increments on every retired cycle and wraps modulo 2^CNT_W.
- Any signal not listed for a state is 0 in that state.

## Timing
- Reset values: state=IDLE, instr_count=0, every other output 0.
- The state register and instr_count are registered. All outputs decode combinationally from state, plus mem_ready for the FETCH and MEMWR strobes. There are no registered outputs beyond state and instr_count.
- Latency with mem_ready tied high, counted FETCH-to-FETCH: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles. Each wait cycle on mem_ready adds one cycle.
- mem_read/mem_write stay asserted continuously until the mem_ready cycle. The memory must not see a deasserted request mid-access.
- Reset mid-instruction: asynchronous return to IDLE, instr_count cleared, in-flight access abandoned, no retired pulse.
- Once FETCH completes, the opcode value is ignored outside DECODE.

## Configuration
- MCU_JUMP_EN defined: opcode 000010 → JUMP state, as above.
- MCU_JUMP_EN undefined: state 11 is not implemented, and 000010 decodes as illegal.

## Structure
- Shared package `mcu_pkg`: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), alu_op and pc_source encodings.
- One sub-module, `mcu_output_decode`: purely combinational state(+mem_ready) → control vector. The FSM, counter and illegal detection stay in the top module.

## Test plan
- Reset: rst_n low for 3 cycles → all outputs 0, state=15. First cycle after release is IDLE; second cycle is FETCH with mem_read=1.
- R-type, mem_ready=1: opcode=000000 → state sequence 0,1,6,7,0. reg_write=reg_dst=1 in state 7. instr_count goes 0→1.
- lw with 2 wait cycles in MEMRD: opcode=100011, mem_ready low for 2 cycles → mem_read held 3 cycles in MEMRD. Total 7 cycles FETCH-to-FETCH; retired pulses in MEMWB.
- Illegal opcode: opcode=111111 → illegal pulses in DECODE, next state FETCH, instr_count unchanged.
- beq then sw back-to-back → pc_write_cond=1 with pc_source=01 for exactly one cycle, then mem_write held until mem_ready. instr_count advances by 2.
- Async reset asserted during MEMRD → state=15 immediately, count=0. With MCU_JUMP_EN undefined, opcode=000010 flags illegal.
